// File: rtl/lfsr_cipher_pkg.sv
// Shared types and Galois LFSR helpers for the LFSR stream cipher.
// Helpers work on a 32-bit container so any LFSR width from 8 to 32 can use them.
package lfsr_cipher_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WARMUP,
        RUN
    } state_t;

    localparam int MAX_W = 32;

    // Narrower states and taps are zero-extended, so the upper bits stay zero through every step.
    function automatic logic [MAX_W-1:0] galois_step(
        input logic [MAX_W-1:0] state,
        input logic [MAX_W-1:0] taps
    );
        logic [MAX_W-1:0] nxt;
        nxt = state >> 1;
        if (state[0]) begin
            nxt = nxt ^ taps;
        end
        return nxt;
    endfunction

    function automatic logic [MAX_W-1:0] word_advance(
        input logic [MAX_W-1:0] state,
        input logic [MAX_W-1:0] taps,
        input int               n
    );
        logic [MAX_W-1:0] s;
        s = state;
        for (int i = 0; i < n; i++) begin
            s = galois_step(s, taps);
        end
        return s;
    endfunction

endpackage

// File: rtl/lfsr_keystream_gen.sv
// Galois LFSR register for the stream cipher.
// It steps one whole keystream word (DATA_W steps) per advance.
module lfsr_keystream_gen
    import lfsr_cipher_pkg::*;
#(
    parameter int              LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS = 16'hB400,
    parameter int              DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              advance,
    output logic [LFSR_W-1:0] lfsr_state
);

    logic [LFSR_W-1:0] advanced;

    assign advanced = LFSR_W'(word_advance(MAX_W'(lfsr_state), MAX_W'(TAPS), DATA_W));

    // A zero seed is replaced by 1 because an all-zero Galois LFSR never leaves zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_state <= LFSR_W'(1);
        end else if (load) begin
            lfsr_state <= (seed == '0) ? LFSR_W'(1) : seed;
        end else if (advance) begin
            lfsr_state <= advanced;
        end
    end

endmodule

// File: rtl/lfsr_stream_cipher.sv
// LFSR stream cipher top: control FSM, one-deep output register and beat counter.
// Each word is XORed with the low DATA_W bits of the keystream generator.
module lfsr_stream_cipher
    import lfsr_cipher_pkg::*;
#(
    parameter int              LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS = 16'hB400,
    parameter int              DATA_W = 8,
    parameter int              WARMUP = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LFSR_W-1:0] seed_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic [15:0]       beat_cnt
);

    localparam int WARM_CNT_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam logic [WARM_CNT_W-1:0] WARM_LAST = WARM_CNT_W'((WARMUP > 0) ? WARMUP - 1 : 0);

    state_t                state;
    logic [WARM_CNT_W-1:0] warm_cnt;
    logic [LFSR_W-1:0]     key_state;
    logic [DATA_W-1:0]     key_word;
    logic                  accept;
    logic                  advance;

    lfsr_keystream_gen #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS),
        .DATA_W (DATA_W)
    ) u_keystream (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (start),
        .seed       (seed_in),
        .advance    (advance),
        .lfsr_state (key_state)
    );

    // A start cycle never accepts, so the seed load always wins over a simultaneous word.
    assign key_word = DATA_W'(key_state);
    assign in_ready = (state == RUN) && !start && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign advance  = accept || ((state == lfsr_cipher_pkg::WARMUP) && !start);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            warm_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            beat_cnt  <= '0;
        end else if (start) begin
            state     <= LOAD;
            warm_cnt  <= '0;
            out_valid <= 1'b0;
            beat_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                end
                LOAD: begin
                    if (WARMUP > 0) begin
                        state <= lfsr_cipher_pkg::WARMUP;
                    end else begin
                        state <= RUN;
                    end
                end
                lfsr_cipher_pkg::WARMUP: begin
                    if (warm_cnt == WARM_LAST) begin
                        state <= RUN;
                    end else begin
                        warm_cnt <= warm_cnt + WARM_CNT_W'(1);
                    end
                end
                RUN: begin
                    if (accept) begin
                        out_data  <= in_data ^ key_word;
                        out_valid <= 1'b1;
                        beat_cnt  <= beat_cnt + 16'd1;
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
